// File: rtl/tlcd_pkg.sv
// Shared constants and types for the text-LCD write path.
//   - HD44780-style instruction/data constants used by the writers
//   - animation geometry (glyph count, line length)
//   - writer FSM and bus-cycle phase encodings
//   - banner text for DDRAM line 1 and helpers to index it
package tlcd_pkg;

    localparam logic [7:0] SET_DDRAM_L1 = 8'h80;
    localparam logic [7:0] SET_DDRAM_L2 = 8'hC0;
    localparam logic [7:0] SPACE        = 8'h20;

    localparam int NUM_GLYPHS = 5;
    localparam int LINE_LEN   = 16;

    // Character 0 of the banner sits in the most significant byte.
    localparam logic [8*LINE_LEN-1:0] BANNER = "HELLO TEXT LCD!!";

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SET_ADDR1  = 3'd1,
        ST_WR_LINE1   = 3'd2,
        ST_SET_ADDR2  = 3'd3,
        ST_WR_LINE2   = 3'd4,
        ST_WAIT_FRAME = 3'd5
    } wr_state_t;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_SETUP = 3'd1,
        PH_EHIGH = 3'd2,
        PH_HOLD  = 3'd3,
        PH_EXEC  = 3'd4
    } bus_phase_t;

    function automatic logic [7:0] banner_byte(input logic [3:0] idx);
        int unsigned pos;
        pos = unsigned'(LINE_LEN - 1) - int'(unsigned'(idx));
        return BANNER[pos*8 +: 8];
    endfunction

    // Width of a down-counter that must hold n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tlcd_bus_cycle.sv
// One timed LCD bus write: setup (E low) / E high / hold (E low) / execute.
// Ports:
//   CLK, RESETN    clock, asynchronous active-low reset
//   req            start a transaction (ignored while busy)
//   rs, data       register select and byte, latched when req is accepted
//   busy           a transaction is in progress
//   done           one-cycle pulse in the final execute cycle
//   tlcd_e/rs/rw/data  LCD pins
//
// phase    | meaning
// ---------+-----------------------------------------------
// PH_IDLE  | waiting for req, E low
// PH_SETUP | RS/DATA stable, E low, SETUP_CYC cycles
// PH_EHIGH | E high, E_HIGH_CYC cycles
// PH_HOLD  | E low, RS/DATA held, HOLD_CYC cycles
// PH_EXEC  | LCD executing, EXEC_CYC cycles; done in the last
module tlcd_bus_cycle
    import tlcd_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 25,
    parameter int HOLD_CYC   = 2,
    parameter int EXEC_CYC   = 2500
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tlcd_e,
    output logic       tlcd_rs,
    output logic       tlcd_rw,
    output logic [7:0] tlcd_data
);

    localparam int MAX_AB  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int MAX_CD  = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = cnt_width(MAX_CYC);

    bus_phase_t       phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rs_q, rs_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             tc;

    assign tc = (cnt == '0);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            phase  <= PH_IDLE;
            cnt    <= '0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            phase  <= phase_nxt;
            cnt    <= cnt_nxt;
            rs_q   <= rs_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = tc ? cnt : cnt - 1'b1;
        rs_nxt    = rs_q;
        data_nxt  = data_q;
        case (phase)
            PH_IDLE: begin
                cnt_nxt = cnt;
                if (req) begin
                    phase_nxt = PH_SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                    rs_nxt    = rs;
                    data_nxt  = data;
                end
            end
            PH_SETUP: begin
                if (tc) begin
                    phase_nxt = PH_EHIGH;
                    cnt_nxt   = CNT_W'(E_HIGH_CYC - 1);
                end
            end
            PH_EHIGH: begin
                if (tc) begin
                    phase_nxt = PH_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                end
            end
            PH_HOLD: begin
                if (tc) begin
                    phase_nxt = PH_EXEC;
                    cnt_nxt   = CNT_W'(EXEC_CYC - 1);
                end
            end
            PH_EXEC: begin
                if (tc) begin
                    phase_nxt = PH_IDLE;
                end
            end
            default: begin
                phase_nxt = PH_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // E decodes straight from the phase register so an async reset drops it at once.
    assign busy      = (phase != PH_IDLE);
    assign done      = (phase == PH_EXEC) && tc;
    assign tlcd_e    = (phase == PH_EHIGH);
    assign tlcd_rs   = rs_q;
    assign tlcd_rw   = 1'b0;
    assign tlcd_data = data_q;

endmodule

// File: rtl/tlcd_anim_writer.sv
// Writes the banner to DDRAM line 1 once, then animates line 2 forever: a
// sprite cycling through CGRAM glyphs 0..4 steps one column right per frame.
// Ports:
//   CLK, RESETN   clock, asynchronous active-low reset
//   START         glyph loading complete (level, sampled only in IDLE)
//   TLCD_E/RS/RW/DATA  LCD bus
//   BUSY          high outside IDLE
//   GLYPH, COL    current sprite glyph code and column
//   FRAME_DONE    one-cycle pulse when the last line-2 byte completes
//
// state         | meaning
// --------------+------------------------------------------------
// ST_IDLE       | wait for START
// ST_SET_ADDR1  | instruction: DDRAM address = line 1
// ST_WR_LINE1   | banner bytes 0..15
// ST_SET_ADDR2  | instruction: DDRAM address = line 2
// ST_WR_LINE2   | sprite row bytes 0..15
// ST_WAIT_FRAME | frame delay, then advance sprite
module tlcd_anim_writer
    import tlcd_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int E_HIGH_CYC  = 25,
    parameter int HOLD_CYC    = 2,
    parameter int EXEC_CYC    = 2500,
    parameter int FRAME_TICKS = 25000000
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       START,
    output logic       TLCD_E,
    output logic       TLCD_RS,
    output logic       TLCD_RW,
    output logic [7:0] TLCD_DATA,
    output logic       BUSY,
    output logic [2:0] GLYPH,
    output logic [3:0] COL,
    output logic       FRAME_DONE
);

    localparam int         FRAME_W  = cnt_width(FRAME_TICKS);
    localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);
    localparam logic [2:0] LAST_GLY = 3'(NUM_GLYPHS - 1);

    wr_state_t          state, state_nxt;
    logic [3:0]         idx, idx_nxt;
    logic               pending, pending_nxt;
    logic               first_pass, first_pass_nxt;
    logic [2:0]         glyph, glyph_nxt;
    logic [3:0]         col, col_nxt;
    logic [FRAME_W-1:0] fcnt, fcnt_nxt;

    logic       issue;
    logic       bus_req;
    logic       bus_rs;
    logic [7:0] bus_data;
    logic       bus_busy;
    logic       bus_done;
    logic       frame_done;

    tlcd_bus_cycle #(
        .SETUP_CYC  (SETUP_CYC),
        .E_HIGH_CYC (E_HIGH_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .EXEC_CYC   (EXEC_CYC)
    ) u_bus (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .req       (bus_req),
        .rs        (bus_rs),
        .data      (bus_data),
        .busy      (bus_busy),
        .done      (bus_done),
        .tlcd_e    (TLCD_E),
        .tlcd_rs   (TLCD_RS),
        .tlcd_rw   (TLCD_RW),
        .tlcd_data (TLCD_DATA)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= ST_IDLE;
            idx        <= 4'd0;
            pending    <= 1'b0;
            first_pass <= 1'b1;
            glyph      <= 3'd0;
            col        <= 4'd0;
            fcnt       <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            pending    <= pending_nxt;
            first_pass <= first_pass_nxt;
            glyph      <= glyph_nxt;
            col        <= col_nxt;
            fcnt       <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        pending_nxt    = pending;
        first_pass_nxt = first_pass;
        glyph_nxt      = glyph;
        col_nxt        = col;
        fcnt_nxt       = fcnt;
        issue          = 1'b0;
        bus_rs         = 1'b0;
        bus_data       = 8'h00;
        frame_done     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = first_pass ? ST_SET_ADDR1 : ST_SET_ADDR2;
                end
            end
            ST_SET_ADDR1: begin
                issue    = 1'b1;
                bus_data = SET_DDRAM_L1;
                if (bus_done) begin
                    state_nxt = ST_WR_LINE1;
                    idx_nxt   = 4'd0;
                end
            end
            ST_WR_LINE1: begin
                issue    = 1'b1;
                bus_rs   = 1'b1;
                bus_data = banner_byte(idx);
                if (bus_done) begin
                    idx_nxt = idx + 4'd1;
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_SET_ADDR2;
                    end
                end
            end
            ST_SET_ADDR2: begin
                issue    = 1'b1;
                bus_data = SET_DDRAM_L2;
                if (bus_done) begin
                    state_nxt = ST_WR_LINE2;
                    idx_nxt   = 4'd0;
                end
            end
            ST_WR_LINE2: begin
                issue    = 1'b1;
                bus_rs   = 1'b1;
                bus_data = (idx == col) ? {5'b00000, glyph} : SPACE;
                if (bus_done) begin
                    idx_nxt = idx + 4'd1;
                    if (idx == LAST_IDX) begin
                        frame_done     = 1'b1;
                        first_pass_nxt = 1'b0;
                        state_nxt      = ST_WAIT_FRAME;
                        fcnt_nxt       = FRAME_W'(FRAME_TICKS - 1);
                    end
                end
            end
            ST_WAIT_FRAME: begin
                // Sprite moves only here, so every line-2 pass sees one position.
                if (fcnt == '0) begin
                    glyph_nxt = (glyph == LAST_GLY) ? 3'd0 : glyph + 3'd1;
                    col_nxt   = col + 4'd1;
                    state_nxt = ST_SET_ADDR2;
                end else begin
                    fcnt_nxt = fcnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // One request per write state; pending clears on done, the state moves
        // on the same edge, and the next state requests once the bus is idle.
        bus_req = issue && !pending && !bus_busy;
        if (bus_req) begin
            pending_nxt = 1'b1;
        end else if (bus_done) begin
            pending_nxt = 1'b0;
        end
    end

    assign BUSY       = (state != ST_IDLE);
    assign GLYPH      = glyph;
    assign COL        = col;
    assign FRAME_DONE = frame_done;

endmodule

// File: tb/tb_tlcd_anim_writer.sv
// Bench for tlcd_anim_writer with short timing parameters.
module tb_tlcd_anim_writer;

    localparam int SETUP = 1;
    localparam int EH    = 2;
    localparam int HOLD  = 1;
    localparam int EXEC  = 2;
    localparam int FT    = 10;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       START = 1'b0;
    logic       TLCD_E, TLCD_RS, TLCD_RW;
    logic [7:0] TLCD_DATA;
    logic       BUSY;
    logic [2:0] GLYPH;
    logic [3:0] COL;
    logic       FRAME_DONE;

    always #5 CLK = ~CLK;

    tlcd_anim_writer #(
        .SETUP_CYC   (SETUP),
        .E_HIGH_CYC  (EH),
        .HOLD_CYC    (HOLD),
        .EXEC_CYC    (EXEC),
        .FRAME_TICKS (FT)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .START      (START),
        .TLCD_E     (TLCD_E),
        .TLCD_RS    (TLCD_RS),
        .TLCD_RW    (TLCD_RW),
        .TLCD_DATA  (TLCD_DATA),
        .BUSY       (BUSY),
        .GLYPH      (GLYPH),
        .COL        (COL),
        .FRAME_DONE (FRAME_DONE)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected {rs,data} of the n-th E strobe after a reset, from the
    // writer's rules: address, banner, then per frame address + sprite row.
    function automatic int exp_strobe(input int n);
        string b;
        int m, f, p, i;
        b = "HELLO TEXT LCD!!";
        if (n == 0) return 32'h080;
        if (n <= 16) return 32'h100 | int'(b[n-1]);
        m = n - 17;
        f = m / 17;
        p = m % 17;
        if (p == 0) return 32'h0C0;
        i = p - 1;
        if (i == f % 16) return 32'h100 | (f % 5);
        return 32'h120;
    endfunction

    // Bus monitor, sampling on the falling clock edge.
    logic [8:0] strobes[$];
    int         widths[$];
    bit         setup_ok[$];
    bit         hold_ok[$];
    int         fd_cnt[$];
    int         fd_glyph[$];
    int         fd_col[$];
    int         fd_cyc[$];
    int         chg_cyc[$];

    logic       e_prev = 1'b0;
    logic       rs_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [6:0] gc_prev = 7'd0;
    bit         stable = 1'b0;
    int         hi = 0;
    int         cyc = 0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (!RESETN) begin
            e_prev    <= 1'b0;
            rs_prev   <= 1'b0;
            data_prev <= 8'h00;
            hi        <= 0;
            gc_prev   <= {GLYPH, COL};
        end else begin
            if (TLCD_E && !e_prev) begin
                strobes.push_back({TLCD_RS, TLCD_DATA});
                hi     <= 1;
                stable <= (TLCD_RS == rs_prev) && (TLCD_DATA == data_prev);
            end else if (TLCD_E) begin
                hi <= hi + 1;
                if (TLCD_RS != rs_prev || TLCD_DATA != data_prev) stable <= 1'b0;
            end
            if (!TLCD_E && e_prev) begin
                widths.push_back(hi);
                setup_ok.push_back(stable);
                hold_ok.push_back((TLCD_RS == rs_prev) && (TLCD_DATA == data_prev));
            end
            if (FRAME_DONE) begin
                fd_cnt.push_back(strobes.size());
                fd_glyph.push_back(int'(GLYPH));
                fd_col.push_back(int'(COL));
                fd_cyc.push_back(cyc);
            end
            if ({GLYPH, COL} != gc_prev) chg_cyc.push_back(cyc);
            e_prev    <= TLCD_E;
            rs_prev   <= TLCD_RS;
            data_prev <= TLCD_DATA;
            gc_prev   <= {GLYPH, COL};
        end
    end

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_E"}, int'(TLCD_E), 0);
        chk({pfx, "_RS"}, int'(TLCD_RS), 0);
        chk({pfx, "_RW"}, int'(TLCD_RW), 0);
        chk({pfx, "_DATA"}, int'(TLCD_DATA), 0);
        chk({pfx, "_BUSY"}, int'(BUSY), 0);
        chk({pfx, "_GLYPH"}, int'(GLYPH), 0);
        chk({pfx, "_COL"}, int'(COL), 0);
        chk({pfx, "_FRAME_DONE"}, int'(FRAME_DONE), 0);
    endtask

    task automatic chk_strobes(input string pfx, input int n);
        for (int i = 0; i < n && i < strobes.size() && i < widths.size(); i++) begin
            chk($sformatf("%s_strobe[%0d]", pfx, i), int'(strobes[i]), exp_strobe(i));
            chk($sformatf("%s_e_width[%0d]", pfx, i), widths[i], EH);
            chk($sformatf("%s_setup_stable[%0d]", pfx, i), int'(setup_ok[i]), 1);
            chk($sformatf("%s_hold_stable[%0d]", pfx, i), int'(hold_ok[i]), 1);
        end
    endtask

    initial begin
        int guard;
        int k;
        bit e_seen;
        bit busy_seen;
        bit busy_drop;
        int nfd;
        int nchg;

        // Reset and idle with START low.
        @(negedge CLK);
        chk_reset_outputs("in_reset");
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        e_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (50) begin
            @(negedge CLK);
            if (TLCD_E) e_seen = 1'b1;
            if (BUSY) busy_seen = 1'b1;
        end
        chk("idle_E_rose", int'(e_seen), 0);
        chk("idle_BUSY_seen", int'(busy_seen), 0);
        chk("idle_strobes", strobes.size(), 0);
        chk_reset_outputs("idle");

        // Start, with START wandering after leaving IDLE; run 17 frames.
        repeat ($urandom_range(0, 20)) @(negedge CLK);
        START = 1'b1;
        guard = 0;
        busy_drop = 1'b0;
        while (fd_cnt.size() < 17 && guard < 20000) begin
            @(negedge CLK);
            guard++;
            if (guard > 2 && !BUSY) busy_drop = 1'b1;
            if (guard > 20 && $urandom_range(0, 7) == 0) START = ~START;
        end
        #1;
        chk("frames_timeout", int'(fd_cnt.size() >= 17), 1);
        chk("busy_dropped", int'(busy_drop), 0);
        chk("strobe_total_17_frames", strobes.size(), 34 + 17 * 16);
        chk_strobes("run", 34 + 17 * 16);

        nfd = (fd_cnt.size() < 17) ? fd_cnt.size() : 17;
        for (int i = 0; i < nfd; i++) begin
            chk($sformatf("frame_done_at_strobe[%0d]", i), fd_cnt[i], 34 + 17 * i);
            chk($sformatf("frame_glyph[%0d]", i), fd_glyph[i], i % 5);
            chk($sformatf("frame_col[%0d]", i), fd_col[i], i % 16);
        end
        chk("sprite_changes", int'(chg_cyc.size() >= 16), 1);
        nchg = (chg_cyc.size() < 16) ? chg_cyc.size() : 16;
        if (nchg > nfd) nchg = nfd;
        for (int i = 0; i < nchg; i++) begin
            chk($sformatf("wait_frame_len[%0d]", i), chg_cyc[i] - fd_cyc[i], FT + 1);
        end

        // Reset while E is high during a line-2 data byte.
        k = $urandom_range(2, 15);
        guard = 0;
        while (!(strobes.size() >= 34 + 17 * 16 + k && TLCD_E) && guard < 2000) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        chk("mid_line2_timeout", int'(guard < 2000), 1);
        chk("mid_line2_E_high", int'(TLCD_E), 1);
        RESETN = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        strobes.delete();
        widths.delete();
        setup_ok.delete();
        hold_ok.delete();
        fd_cnt.delete();
        fd_glyph.delete();
        fd_col.delete();
        fd_cyc.delete();
        chg_cyc.delete();
        START = 1'b1;
        repeat (3) @(negedge CLK);
        chk("held_reset_E", int'(TLCD_E), 0);
        RESETN = 1'b1;

        // Full first pass must repeat from the line-1 address.
        guard = 0;
        while (fd_cnt.size() < 1 && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        #1;
        chk("restart_timeout", int'(fd_cnt.size() >= 1), 1);
        chk("restart_strobes", strobes.size(), 34);
        chk_strobes("restart", 34);
        if (fd_cnt.size() >= 1) begin
            chk("restart_frame_done_at", fd_cnt[0], 34);
            chk("restart_glyph", fd_glyph[0], 0);
            chk("restart_col", fd_col[0], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
